// File: rtl/fphub_div_packer.sv
// Output stage of the radix-2 SRT divider: resolves the signed-digit quotient, normalizes it and packs a HUB float.
// Optional flag outputs are enabled with the FPHUB_DIV_PACK_FLAGS_EN macro.
module fphub_div_packer #(
   parameter int unsigned M    = 23,
   parameter int unsigned E    = 8,
   parameter int unsigned Q    = M + 3,
   parameter int unsigned BIAS = 2**(E-1) - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [Q-1:0]     q_pos,
   input  logic [Q-1:0]     q_neg,
   input  logic             rem_neg,
   input  logic             x_sign,
   input  logic             d_sign,
   input  logic [E-1:0]     x_exp,
   input  logic [E-1:0]     d_exp,
   input  logic             special,
   input  logic [M+E:0]     special_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [M+E:0]     res,
   output logic             ovf,
   output logic             unf
);

   localparam int unsigned RW = M + E + 1;
   localparam int unsigned EW = E + 2;
   localparam logic [E:0]  EXP_MAX = (E+1)'((2**E) - 1);

   typedef enum logic [2:0] {IDLE, RESOLVE, NORM, PACK, HOLD} state_t;

   state_t          state, state_n;
   logic [Q-1:0]    qp_r, qp_n, qn_r, qn_n;
   logic            rn_r, rn_n, sign_r, sign_n, zero_r, zero_n;
   logic [E-1:0]    xe_r, xe_n, de_r, de_n;
   logic [Q:0]      q_r, q_n;
   logic [EW-1:0]   e_r, e_n;
   logic [RW-1:0]   res_r, res_n;
   logic            out_valid_r, in_ready_r;
   logic [Q:0]      q_diff;
   logic [EW-1:0]   e_calc;
   logic            e_le_zero, e_sat;

   // Redundant-to-conventional conversion with the remainder-sign correction
   assign q_diff    = {1'b0, qp_r} - {1'b0, qn_r} - (Q+1)'(rn_r);
   assign e_calc    = {2'b00, xe_r} - {2'b00, de_r} + EW'(BIAS);
   assign e_le_zero = e_r[EW-1] || (e_r == '0);
   assign e_sat     = !e_r[EW-1] && (e_r[E:0] >= EXP_MAX);

`ifdef FPHUB_DIV_PACK_FLAGS_EN
   logic ovf_r, ovf_n, unf_r, unf_n;
   assign ovf = ovf_r;
   assign unf = unf_r;
`else
   assign ovf = 1'b0;
   assign unf = 1'b0;
`endif

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign res       = res_r;

   // Next-state and datapath
   always_comb begin
      state_n = state;
      qp_n    = qp_r;
      qn_n    = qn_r;
      rn_n    = rn_r;
      sign_n  = sign_r;
      xe_n    = xe_r;
      de_n    = de_r;
      q_n     = q_r;
      e_n     = e_r;
      zero_n  = zero_r;
      res_n   = res_r;
`ifdef FPHUB_DIV_PACK_FLAGS_EN
      ovf_n   = ovf_r;
      unf_n   = unf_r;
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
               qp_n   = q_pos;
               qn_n   = q_neg;
               rn_n   = rem_neg;
               sign_n = x_sign ^ d_sign;
               xe_n   = x_exp;
               de_n   = d_exp;
               zero_n = 1'b0;
               if (special) begin
                  res_n   = special_res;
`ifdef FPHUB_DIV_PACK_FLAGS_EN
                  ovf_n   = 1'b0;
                  unf_n   = 1'b0;
`endif
                  state_n = HOLD;
               end else begin
                  state_n = RESOLVE;
               end
            end
         end
         RESOLVE: begin
            q_n     = q_diff[Q] ? (~q_diff + (Q+1)'(1)) : q_diff;
            e_n     = e_calc;
            state_n = NORM;
         end
         NORM: begin
            if (q_r[Q-1]) begin
               state_n = PACK;
            end else if (q_r == '0) begin
               zero_n  = 1'b1;
               state_n = PACK;
            end else begin
               q_n = q_r << 1;
               e_n = e_r - EW'(1);
            end
         end
         PACK: begin
`ifdef FPHUB_DIV_PACK_FLAGS_EN
            ovf_n = 1'b0;
            unf_n = 1'b0;
`endif
            if (zero_r) begin
               res_n = {sign_r, (RW-1)'(0)};
            end else if (e_le_zero) begin
               res_n = {sign_r, (RW-1)'(0)};
`ifdef FPHUB_DIV_PACK_FLAGS_EN
               unf_n = 1'b1;
`endif
            end else if (e_sat) begin
               res_n = {sign_r, {E{1'b1}}, M'(0)};
`ifdef FPHUB_DIV_PACK_FLAGS_EN
               ovf_n = 1'b1;
`endif
            end else begin
               // Truncation below the ILSB is HUB round-to-nearest
               res_n = {sign_r, e_r[E-1:0], q_r[Q-2:Q-1-M]};
            end
            state_n = HOLD;
         end
         HOLD: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         qp_r        <= '0;
         qn_r        <= '0;
         rn_r        <= 1'b0;
         sign_r      <= 1'b0;
         xe_r        <= '0;
         de_r        <= '0;
         q_r         <= '0;
         e_r         <= '0;
         zero_r      <= 1'b0;
         res_r       <= '0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
`ifdef FPHUB_DIV_PACK_FLAGS_EN
         ovf_r       <= 1'b0;
         unf_r       <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         qp_r        <= qp_n;
         qn_r        <= qn_n;
         rn_r        <= rn_n;
         sign_r      <= sign_n;
         xe_r        <= xe_n;
         de_r        <= de_n;
         q_r         <= q_n;
         e_r         <= e_n;
         zero_r      <= zero_n;
         res_r       <= res_n;
         out_valid_r <= (state_n == HOLD);
         in_ready_r  <= (state_n == IDLE);
`ifdef FPHUB_DIV_PACK_FLAGS_EN
         ovf_r       <= ovf_n;
         unf_r       <= unf_n;
`endif
      end
   end

endmodule

// File: tb/tb_fphub_div_packer.sv
// Self-checking bench for fphub_div_packer: directed cases plus randomized traffic against an arithmetic model.
module tb_fphub_div_packer;

   localparam int QW = 26;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, rem_neg, x_sign, d_sign, special;
   logic [25:0] q_pos, q_neg;
   logic [7:0]  x_exp, d_exp;
   logic [31:0] special_res, res;
   logic        out_valid, out_ready, ovf, unf;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fphub_div_packer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .q_pos(q_pos), .q_neg(q_neg), .rem_neg(rem_neg),
      .x_sign(x_sign), .d_sign(d_sign), .x_exp(x_exp), .d_exp(d_exp),
      .special(special), .special_res(special_res),
      .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .ovf(ovf), .unf(unf)
   );

   // Quotient value -> normalized HUB result; lat = -1 means "zero quotient, bounded latency"
   function automatic void model(input logic [25:0] qp, input logic [25:0] qn, input logic rn,
                                 input logic xs, input logic ds, input logic [7:0] xe,
                                 input logic [7:0] de, output logic [31:0] r, output logic o,
                                 output logic u, output int lat);
      longint v;
      int     k, e;
      logic   s;
      logic [22:0] mant;
      s = xs ^ ds;
      v = longint'(qp) - longint'(qn) - longint'(rn);
      if (v < 0) v = -v;
      o = 1'b0;
      u = 1'b0;
      if (v == 0) begin
         r   = {s, 31'h0};
         lat = -1;
      end else begin
         k = 0;
         while (v < (longint'(1) << 25)) begin
            v = v * 2;
            k++;
         end
         e    = int'(xe) - int'(de) + 127 - k;
         mant = 23'(v >> 2);
         lat  = 4 + k;
         if (e <= 0) begin
            r = {s, 31'h0};
            u = 1'b1;
         end else if (e >= 255) begin
            r = {s, 8'hFF, 23'h0};
            o = 1'b1;
         end else begin
            r = {s, 8'(e), mant};
         end
      end
`ifndef FPHUB_DIV_PACK_FLAGS_EN
      o = 1'b0;
      u = 1'b0;
`endif
   endfunction

   task automatic scramble_inputs();
      q_pos       = 26'($urandom);
      q_neg       = 26'($urandom);
      rem_neg     = 1'($urandom);
      x_sign      = 1'($urandom);
      d_sign      = 1'($urandom);
      x_exp       = 8'($urandom);
      d_exp       = 8'($urandom);
      special     = 1'($urandom);
      special_res = $urandom;
   endtask

   task automatic run_txn(input logic [25:0] qp, input logic [25:0] qn, input logic rn,
                          input logic xs, input logic ds, input logic [7:0] xe, input logic [7:0] de,
                          input logic sp, input logic [31:0] spr, input int stall, input string tag);
      logic [31:0] r;
      logic        o, u;
      int          lat_exp, lat, guard;
      if (sp) begin
         r = spr; o = 1'b0; u = 1'b0; lat_exp = 1;
      end else begin
         model(qp, qn, rn, xs, ds, xe, de, r, o, u, lat_exp);
      end
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s in_ready_before_accept: got %b want 1", tag, in_ready);
      end
      q_pos = qp; q_neg = qn; rem_neg = rn; x_sign = xs; d_sign = ds;
      x_exp = xe; d_exp = de; special = sp; special_res = spr; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      scramble_inputs();
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      n_vec++;
      if (out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL %s out_valid_timeout: got %b want 1", tag, out_valid);
      end
      n_vec++;
      if ((lat_exp < 0) ? (lat > QW + 3) : (lat != lat_exp)) begin
         n_err++;
         $display("FAIL %s latency: got %0d want %0d (-1 = at most %0d)", tag, lat, lat_exp, QW + 3);
      end
      n_vec++;
      if (res !== r) begin
         n_err++;
         $display("FAIL %s res: got %h want %h", tag, res, r);
      end
      n_vec++;
      if (ovf !== o || unf !== u) begin
         n_err++;
         $display("FAIL %s flags: got ovf=%b unf=%b want ovf=%b unf=%b", tag, ovf, unf, o, u);
      end
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'($urandom);
         @(negedge clk);
         n_vec++;
         if (res !== r || out_valid !== 1'b1 || in_ready !== 1'b0 || ovf !== o || unf !== u) begin
            n_err++;
            $display("FAIL %s hold_stable: got res=%h ov=%b rdy=%b want res=%h ov=1 rdy=0",
                     tag, res, out_valid, in_ready, r);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s after_handshake: got ov=%b rdy=%b want ov=0 rdy=1", tag, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 32'h0 || ovf !== 1'b0 || unf !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got rdy=%b ov=%b res=%h ovf=%b unf=%b want 1 0 0 0 0",
                  in_ready, out_valid, res, ovf, unf);
      end
   endtask

   task automatic test_directed();
      run_txn(26'h3000000, 26'h0, 1'b0, 1'b0, 1'b0, 8'd127, 8'd127, 1'b0, 32'h0, 0, "case1");
      run_txn(26'h1800000, 26'h0, 1'b0, 1'b1, 1'b0, 8'd127, 8'd127, 1'b0, 32'h0, 0, "case2_k1");
      run_txn(26'h2800000, 26'h0800000, 1'b1, 1'b0, 1'b0, 8'd127, 8'd127, 1'b0, 32'h0, 0, "case3_redundant");
      run_txn(26'h2000000, 26'h0, 1'b0, 1'b0, 1'b0, 8'd254, 8'd1, 1'b0, 32'h0, 0, "case4_ovf");
      run_txn(26'h2000000, 26'h0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd200, 1'b0, 32'h0, 0, "case4_unf");
      run_txn(26'h0000001, 26'h0, 1'b1, 1'b1, 1'b0, 8'd127, 8'd127, 1'b0, 32'h0, 0, "zero_quot");
      run_txn(26'h0000001, 26'h0, 1'b0, 1'b0, 1'b0, 8'd150, 8'd100, 1'b0, 32'h0, 0, "max_shift");
      run_txn(26'h3FFFFFF, 26'h0, 1'b0, 1'b0, 1'b0, 8'd128, 8'd1, 1'b0, 32'h0, 0, "exp_254_edge");
   endtask

   task automatic test_backpressure();
      run_txn(26'h3000000, 26'h0, 1'b0, 1'b0, 1'b0, 8'd127, 8'd127, 1'b0, 32'h0, 10, "stall10");
      run_txn(26'h0, 26'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 32'h7FC00000, 0, "special");
      run_txn(26'h0, 26'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 32'h7FC00000, 4, "special_stall");
   endtask

   task automatic test_reset_mid();
      logic bad;
      q_pos = 26'h0000001; q_neg = 26'h0; rem_neg = 1'b0; x_sign = 1'b0; d_sign = 1'b0;
      x_exp = 8'd127; d_exp = 8'd127; special = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid_norm: got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
      end
      bad = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
         n_err++;
         $display("FAIL reset_abandon: got out_valid=1 want 0");
      end
      run_txn(26'h3000000, 26'h0, 1'b0, 1'b0, 1'b0, 8'd127, 8'd127, 1'b0, 32'h0, 0, "after_reset");
   endtask

   task automatic test_random();
      logic [25:0] qp, qn;
      int sel;
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 7);
         if (sel < 3) begin
            qp = 26'($urandom) | 26'h2000000;
            qn = 26'($urandom) & ~qp & 26'h0FFFFFF;
         end else if (sel < 6) begin
            qp = (26'($urandom) & 26'h1FFFFFF) | 26'h1000000;
            qn = 26'($urandom) & ~qp & 26'h07FFFFF;
         end else begin
            qp = 26'($urandom_range(1, 255));
            qn = 26'h0;
         end
         run_txn(qp, qn, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      q_pos = '0; q_neg = '0; rem_neg = 1'b0; x_sign = 1'b0; d_sign = 1'b0;
      x_exp = '0; d_exp = '0; special = 1'b0; special_res = '0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/fphub_div_packer.md
# fphub_div_packer

Output stage placed directly downstream of the radix-2 SRT divider. It consumes the redundant signed-digit quotient (positive/negative digit vectors), the final-remainder sign and the operand sign/exponent fields. It resolves them into a conventional quotient, normalizes it, computes the biased exponent with overflow/underflow saturation, and emits one packed HUB floating-point result per transaction under a valid/ready handshake.

## Interface
Parameters:
- M, 23, mantissa width (fraction bits, no implicit one)
- E, 8, exponent width
- Q, M+3, quotient digit count; digit Q-1 has weight 2^0, digit i has weight 2^(i-Q+1)
- BIAS, 2**(E-1)-1, exponent bias

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream transaction valid
- in_ready  out  1  block can accept a transaction
- q_pos  in  Q  digits equal to +1
- q_neg  in  Q  digits equal to -1 (never set in the same bit position as q_pos)
- rem_neg  in  1  final partial remainder is negative
- x_sign, d_sign  in  1 each  operand signs
- x_exp, d_exp  in  E each  operand biased exponents
- special  in  1  special case already resolved upstream
- special_res  in  M+E+1  result to forward when special=1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- res  out  M+E+1  {sign, exponent, mantissa} HUB result
- ovf, unf  out  1 each  overflow / underflow flags, qualified by out_valid

## Operation
- FSM states: IDLE, RESOLVE, NORM, PACK, HOLD. in_ready = (state==IDLE).
- IDLE: on in_valid, capture all inputs. special=1 -> HOLD with res=special_res, ovf=unf=0. Otherwise -> RESOLVE.
- RESOLVE: q = q_pos - q_neg - rem_neg, computed at Q+1 bits. For positive operand mantissas q is non-negative; the magnitude is used. Exponent register e = x_exp - d_exp + BIAS, signed, E+2 bits. Next state is NORM.
- NORM: if q[Q-1]==1, go to PACK. If q==0, go to PACK with a zero flag. Otherwise shift q left by 1 and decrement e, at most one shift per cycle. The shift count k is bounded by Q-1.
- PACK:
  - sign = x_sign ^ d_sign.
  - Zero flag or e<=0 gives a signed zero (exponent 0, mantissa 0) and unf=1; a zero flag alone gives unf=0.
  - e >= 2^E-1 gives sign, exponent all ones, mantissa 0, and ovf=1.
  - Otherwise exponent = e[E-1:0] and mantissa = q[Q-2:Q-1-M]. Lower bits are truncated, which is HUB round-to-nearest. The implicit ILSB is not stored.
  - Next state is HOLD.
- HOLD: out_valid=1. res, ovf and unf are held stable until out_valid && out_ready, then go to IDLE.
- in_valid is ignored outside IDLE. Inputs need only be stable in the accept cycle.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, res=0, ovf=0, unf=0, internal q/e=0.
- Reset asserted in any state abandons the transaction; no output is produced. Reset dominates a simultaneous handshake.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - special: 1 cycle
  - normal: 4+k cycles (k=0 for quotient in [1,2), k=1 for [0.5,1))
  - zero quotient: Q+3 cycles at most
- Throughput: one transaction per (latency+1) cycles minimum. The handshake-completion cycle returns to IDLE, and in_ready rises in the following cycle, so there is no same-cycle pass-through.
- out_ready held low: the block stalls indefinitely in HOLD with outputs constant.

## Configuration
- FPHUB_DIV_PACK_FLAGS_EN defined: ovf and unf are computed as above.
- Not defined: ovf and unf are tied to 0. The flag registers are removed. Saturation of res to infinity or zero is unchanged.

## Test plan
1. q_pos=26'h3000000, q_neg=0, rem_neg=0, exps 127/127, signs 0/0 -> res=0x3FC00000, ovf=unf=0, out_valid 4 cycles after accept.
2. q_pos=26'h1800000, exps 127/127, x_sign=1 -> res=0xBF400000, out_valid after 5 cycles (k=1).
3. Redundant input: q_pos=26'h2800000, q_neg=26'h0800000, rem_neg=1, exps 127/127 -> q=26'h1FFFFFF, res=0x3F7FFFFF.
4. q_pos=26'h2000000, x_exp=254, d_exp=1 -> res=0x7F800000, ovf=1. With x_exp=1, d_exp=200 -> res=0x00000000, unf=1. With the macro undefined, the same res values and ovf=unf=0.
5. Backpressure and bypass:
   - out_ready low for 10 cycles in HOLD: res stable, in_ready=0, and in_valid pulses are ignored. Raising out_ready completes the transfer; in_ready=1 on the next cycle.
   - special=1, special_res=0x7FC00000: res=0x7FC00000 one cycle after accept.
6. rst pulsed during NORM: out_valid stays 0, in_ready=1 the cycle after reset. The next transaction (case 1) produces the correct result.
